ghost_motion_tracker: RTL

- Owns the authoritative pixel position of one ghost and closes the loop with a ghost control block.
- Presents x/y to the controller and samples its next_x/next_y/ghost_direction proposal once per move tick.
- Checks the proposal against bounds, step legality and tilemap_walls, then commits it or holds position.
- Also handles the eaten/respawn sequence. Feeds the renderer and the collision logic.

---
 rtl/ghost_motion_tracker_pkg.sv | 44 ++++
 rtl/ghost_motion_tracker_lookup.sv | 37 +++
 rtl/ghost_motion_tracker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ghost_motion_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ghost_motion_tracker_pkg                                  |
// | Brief    : Shared playfield geometry, headings, tracker state codes  |
// |            and the tile index helper used by the ghost/pacman movers.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ghost_motion_tracker_pkg;

  // Playfield geometry in pixels and tiles (20 px tiles on 640x480).
  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int TILE_ROW_NUM = 24;
  localparam int TILE_COL_NUM = 32;
  localparam int TILE_NUM     = TILE_ROW_NUM * TILE_COL_NUM;

  localparam int X_W   = $clog2(WIDTH);
  localparam int Y_W   = $clog2(HEIGHT);
  localparam int COL_W = $clog2(TILE_COL_NUM);
  localparam int ROW_W = $clog2(TILE_ROW_NUM);
  localparam int IDX_W = $clog2(TILE_NUM);

  // Heading encodings shared with the controllers.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Tracker states.
  typedef enum logic [1:0] {
    GMT_WAIT   = 2'd0,
    GMT_SAMPLE = 2'd1,
    GMT_DECIDE = 2'd2,
    GMT_HOUSE  = 2'd3
  } gmt_state_e;

  // Row-major tile index: row*TILE_COL_NUM + col.
  function automatic logic [IDX_W-1:0] tile_index(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return IDX_W'(row) * IDX_W'(TILE_COL_NUM) + IDX_W'(col);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_motion_tracker_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tile_wall_lookup                                          |
// | Brief    : Combinational pixel-to-tile conversion plus wall-bit      |
// |            lookup for an (already registered) tile coordinate.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tile_wall_lookup
  import ghost_motion_tracker_pkg::*;
#(
  parameter int TILE = 20
) (
  input  logic [X_W-1:0]      px,
  input  logic [Y_W-1:0]      py,
  output logic [COL_W-1:0]    col,
  output logic [ROW_W-1:0]    row,
  input  logic [ROW_W-1:0]    tile_row,
  input  logic [COL_W-1:0]    tile_col,
  input  logic [TILE_NUM-1:0] walls,
  output logic                wall
);

  localparam logic [X_W-1:0] TILE_X = X_W'(TILE);
  localparam logic [Y_W-1:0] TILE_Y = Y_W'(TILE);

  logic [IDX_W-1:0] w_idx;

  // Division by a constant tile size; callers register the result so the
  // divider never sits in the same path as the wall lookup.
  assign col = COL_W'(px / TILE_X);
  assign row = ROW_W'(py / TILE_Y);

  assign w_idx = tile_index(tile_row, tile_col);
  assign wall  = walls[w_idx];

endmodule
`default_nettype wire

// File: rtl/ghost_motion_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ghost_motion_tracker                                      |
// | Brief    : Authoritative ghost position. Samples the controller      |
// |            proposal once per move tick, validates bounds / step /    |
// |            walls, commits or holds, and runs the eaten/respawn hold. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ghost_motion_tracker
  import ghost_motion_tracker_pkg::*;
#(
  parameter int START_X       = 340,
  parameter int START_Y       = 240,
  parameter int TILE          = 20,
  parameter int MOVE_DIV      = 2500000,
  parameter int RESPAWN_TICKS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                eaten,
  input  logic [X_W-1:0]      next_x,
  input  logic [Y_W-1:0]      next_y,
  input  logic [1:0]          ghost_direction,
  input  logic [TILE_NUM-1:0] tilemap_walls,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [1:0]          heading,
  output logic                moved,
  output logic                blocked,
  output logic                in_house
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int HC_W  = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
  localparam int XS_W  = X_W + 1;
  localparam int YS_W  = Y_W + 1;

  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic [HC_W-1:0]        HC_LAST  = HC_W'(RESPAWN_TICKS - 1);
  localparam logic [X_W-1:0]         X_MAX    = X_W'(WIDTH - TILE);
  localparam logic [Y_W-1:0]         Y_MAX    = Y_W'(HEIGHT - TILE);
  localparam logic [X_W-1:0]         X_HOME   = X_W'(START_X);
  localparam logic [Y_W-1:0]         Y_HOME   = Y_W'(START_Y);
  localparam logic signed [XS_W-1:0] STEP_X   = XS_W'(TILE);
  localparam logic signed [YS_W-1:0] STEP_Y   = YS_W'(TILE);

  gmt_state_e r_state;
  gmt_state_e w_state_next;

  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic [HC_W-1:0]  r_house_cnt;
  logic             w_house_done;

  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [1:0]       r_heading;
  logic [X_W-1:0]   r_cand_x;
  logic [Y_W-1:0]   r_cand_y;
  logic [1:0]       r_cand_dir;
  logic [COL_W-1:0] r_cand_col;
  logic [ROW_W-1:0] r_cand_row;

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_wall;

  logic signed [XS_W-1:0] w_dx;
  logic signed [YS_W-1:0] w_dy;
  logic                   w_in_bounds;
  logic                   w_step_ok;
  logic                   w_legal;

  // Tile coordinates come from the live proposal (captured in SAMPLE);
  // the wall bit is looked up from the captured tile in DECIDE.
  tile_wall_lookup #(
    .TILE (TILE)
  ) u_lookup (
    .px       (next_x),
    .py       (next_y),
    .col      (w_col),
    .row      (w_row),
    .tile_row (r_cand_row),
    .tile_col (r_cand_col),
    .walls    (tilemap_walls),
    .wall     (w_wall)
  );

  assign w_tick       = enable && (r_tick_cnt == CNT_LAST);
  assign w_house_done = w_tick && (r_house_cnt == HC_LAST);

  // Signed one-bit-wider differences so a wrapped x-TILE cannot alias to a legal step.
  assign w_dx = $signed({1'b0, r_cand_x}) - $signed({1'b0, r_x});
  assign w_dy = $signed({1'b0, r_cand_y}) - $signed({1'b0, r_y});

  assign w_in_bounds = (r_cand_x <= X_MAX) && (r_cand_y <= Y_MAX);
  assign w_step_ok   = ((w_dx == '0) && ((w_dy == STEP_Y) || (w_dy == -STEP_Y))) ||
                       ((w_dy == '0) && ((w_dx == STEP_X) || (w_dx == -STEP_X)));
  assign w_legal     = w_in_bounds && w_step_ok && !w_wall;

  assign x        = r_x;
  assign y        = r_y;
  assign heading  = r_heading;
  assign in_house = (r_state == GMT_HOUSE);

  // Free-running move-tick divider, frozen while the game is paused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (enable) begin
      r_tick_cnt <= (r_tick_cnt == CNT_LAST) ? '0 : r_tick_cnt + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= GMT_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and the one-cycle commit/reject pulses; eaten overrides everything.
  always_comb begin
    w_state_next = r_state;
    moved        = 1'b0;
    blocked      = 1'b0;
    if (eaten) begin
      w_state_next = GMT_HOUSE;
    end else begin
      case (r_state)
        GMT_WAIT:   if (w_tick) w_state_next = GMT_SAMPLE;
        GMT_SAMPLE: w_state_next = GMT_DECIDE;
        GMT_DECIDE: begin
          moved        = w_legal;
          blocked      = !w_legal;
          w_state_next = GMT_WAIT;
        end
        GMT_HOUSE:  if (w_house_done) w_state_next = GMT_WAIT;
        default:    w_state_next = GMT_WAIT;
      endcase
    end
  end

  // Position, candidate capture and respawn-hold counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x         <= X_HOME;
      r_y         <= Y_HOME;
      r_heading   <= DIR_UP;
      r_cand_x    <= '0;
      r_cand_y    <= '0;
      r_cand_dir  <= DIR_UP;
      r_cand_col  <= '0;
      r_cand_row  <= '0;
      r_house_cnt <= '0;
    end else if (eaten) begin
      r_x         <= X_HOME;
      r_y         <= Y_HOME;
      r_heading   <= DIR_UP;
      r_house_cnt <= '0;
    end else begin
      case (r_state)
        GMT_SAMPLE: begin
          r_cand_x   <= next_x;
          r_cand_y   <= next_y;
          r_cand_dir <= ghost_direction;
          r_cand_col <= w_col;
          r_cand_row <= w_row;
        end
        GMT_DECIDE: begin
          r_heading <= r_cand_dir;
          if (w_legal) begin
            r_x <= r_cand_x;
            r_y <= r_cand_y;
          end
        end
        GMT_HOUSE: begin
          if (w_tick) begin
            r_house_cnt <= w_house_done ? '0 : r_house_cnt + HC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
